sokoban_move_sequencer: RTL

//  Sequences one Sokoban move per video frame against the shared map tile RAM.

---
 rtl/sokoban_move_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sokoban_move_sequencer.sv
// sokoban_move_sequencer
//   Runs at most one Sokoban move per video frame against the shared map
//   tile RAM. It holds the player position, the count of boxes sitting on
//   targets and the game state. It bids for the single-port tile RAM with
//   ram_req; the renderer hands over the port with ram_gnt during blanking.
//   A move reads the tile ahead (and the one beyond it for a push), then
//   writes both tiles back and updates px/py and the win status.
//
// Parameters
//   MAP_W, MAP_H      map size in tiles
//   START_X, START_Y  player position after reset
//   NUM_BOX           boxes in the level; the game is won when all are on targets
//
// Ports
//   clk         pixel clock, the only clock
//   reset       asynchronous, active-low reset
//   vs          frame sync; a rising edge opens the move window
//   dir_move    one-hot direction: 0001 up, 0010 down, 0100 left, 1000 right
//   ram_gnt     tile RAM port granted this cycle
//   ram_rdata   tile read data, valid one clk after the read is accepted
//   ram_req     tile RAM access request
//   ram_addr    tile address = y*MAP_W + x
//   ram_we      write strobe, only ever high together with ram_gnt
//   ram_wdata   tile code: 0 empty, 1 wall, 2 box, 3 target, 5 box-on-target
//   px, py      player tile coordinates
//   busy        a move transaction is in progress
//   game_state  01 start, 10 gaming, 11 win
//   step_cnt    (STEP_COUNT_EN only) moves that changed px/py, saturating at 999
//
// Build option
//   `define STEP_COUNT_EN adds the step_cnt output and its counter.

module sokoban_move_sequencer #(
    parameter int MAP_W   = 16,
    parameter int MAP_H   = 12,
    parameter int START_X = 6,
    parameter int START_Y = 3,
    parameter int NUM_BOX = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vs,
    input  logic [3:0] dir_move,
    input  logic       ram_gnt,
    input  logic [2:0] ram_rdata,
    output logic       ram_req,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [2:0] ram_wdata,
    output logic [3:0] px,
    output logic [3:0] py,
    output logic       busy,
    output logic [1:0] game_state
`ifdef STEP_COUNT_EN
    ,
    output logic [9:0] step_cnt
`endif
);

    localparam int CW = (NUM_BOX < 1) ? 1 : $clog2(NUM_BOX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_RD1, S_CAP1, S_RD2, S_CAP2, S_WR2, S_WR1, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        GS_START = 2'b01,
        GS_GAME  = 2'b10,
        GS_WIN   = 2'b11
    } gs_t;

    state_t        state, state_nx;
    gs_t           gs;
    logic          vs_q;
    logic          vs_edge;
    logic          dir_ok;
    logic          accept;
    logic [3:0]    dir_q;
    logic [2:0]    t1_q, t2_q;
    logic [CW-1:0] tgt_cnt, tgt_nx;
    int            tgt_sum;
    logic [3:0]    x1, y1, x2, y2;
    logic          t1_in, t2_in;
    logic          t1_free, t1_box, t2_blocked;
    logic          step_upd;

    function automatic logic [7:0] tile_addr(input logic [3:0] x, input logic [3:0] y);
        return 8'(int'(y) * MAP_W + int'(x));
    endfunction

    assign vs_edge    = vs & ~vs_q;
    assign game_state = gs;

    always_comb begin
        dir_ok = 1'b0;
        case (dir_move)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: dir_ok = 1'b1;
            default:                            dir_ok = 1'b0;
        endcase
    end

    // A vs edge arriving mid-transaction is simply lost.
    assign accept = vs_edge && (gs == GS_GAME) && (state == S_IDLE) && dir_ok;

    // T1 = P+d and T2 = P+2d with their in-map checks; no wrap at the edges.
    always_comb begin
        x1    = px;
        y1    = py;
        x2    = px;
        y2    = py;
        t1_in = 1'b0;
        t2_in = 1'b0;
        case (dir_q)
            4'b0001: begin
                y1    = py - 4'd1;
                y2    = py - 4'd2;
                t1_in = (py != 4'd0);
                t2_in = (py >= 4'd2);
            end
            4'b0010: begin
                y1    = py + 4'd1;
                y2    = py + 4'd2;
                t1_in = (int'(py) < MAP_H - 1);
                t2_in = (int'(py) < MAP_H - 2);
            end
            4'b0100: begin
                x1    = px - 4'd1;
                x2    = px - 4'd2;
                t1_in = (px != 4'd0);
                t2_in = (px >= 4'd2);
            end
            4'b1000: begin
                x1    = px + 4'd1;
                x2    = px + 4'd2;
                t1_in = (int'(px) < MAP_W - 1);
                t2_in = (int'(px) < MAP_W - 2);
            end
            default: ;
        endcase
    end

    assign t1_free    = (ram_rdata == 3'd0) || (ram_rdata == 3'd3);
    assign t1_box     = (ram_rdata == 3'd2) || (ram_rdata == 3'd5);
    assign t2_blocked = (ram_rdata == 3'd1) || (ram_rdata == 3'd2) || (ram_rdata == 3'd5);

    // Box-on-target count after the WR1 update, clamped to 0..NUM_BOX.
    always_comb begin
        tgt_sum = int'(tgt_cnt);
        if (t2_q == 3'd3) tgt_sum = tgt_sum + 1;
        if (t1_q == 3'd5) tgt_sum = tgt_sum - 1;
        if (tgt_sum < 0) tgt_sum = 0;
        if (tgt_sum > NUM_BOX) tgt_sum = NUM_BOX;
        tgt_nx = CW'(tgt_sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        ram_req   = (state != S_IDLE) && (state != S_DONE);
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            S_IDLE: if (accept) state_nx = S_REQ;
            S_REQ:  if (ram_gnt) state_nx = S_RD1;
            S_RD1: begin
                ram_addr = tile_addr(x1, y1);
                if (!t1_in)       state_nx = S_DONE;
                else if (ram_gnt) state_nx = S_CAP1;
            end
            S_CAP1: begin
                if (t1_box) state_nx = S_RD2;
                else        state_nx = S_DONE;
            end
            S_RD2: begin
                ram_addr = tile_addr(x2, y2);
                if (!t2_in)       state_nx = S_DONE;
                else if (ram_gnt) state_nx = S_CAP2;
            end
            S_CAP2: begin
                if (t2_blocked) state_nx = S_DONE;
                else            state_nx = S_WR2;
            end
            S_WR2: begin
                ram_addr  = tile_addr(x2, y2);
                ram_wdata = (t2_q == 3'd3) ? 3'd5 : 3'd2;
                ram_we    = ram_gnt;
                if (ram_gnt) state_nx = S_WR1;
            end
            S_WR1: begin
                ram_addr  = tile_addr(x1, y1);
                ram_wdata = (t1_q == 3'd5) ? 3'd3 : 3'd0;
                ram_we    = ram_gnt;
                if (ram_gnt) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign step_upd = ((state == S_CAP1) && t1_free) || ((state == S_WR1) && ram_gnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_q    <= 1'b0;
            dir_q   <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            tgt_cnt <= '0;
            px      <= 4'(START_X);
            py      <= 4'(START_Y);
            gs      <= GS_START;
        end else begin
            vs_q <= vs;
            if (accept) dir_q <= dir_move;
            if (state == S_CAP1) t1_q <= ram_rdata;
            if (state == S_CAP2) t2_q <= ram_rdata;
            if ((state == S_WR1) && ram_gnt) tgt_cnt <= tgt_nx;
            if (step_upd) begin
                px <= x1;
                py <= y1;
            end
            case (gs)
                GS_START: if (vs_edge) gs <= GS_GAME;
                GS_GAME:  if (int'(tgt_cnt) == NUM_BOX) gs <= GS_WIN;
                default:  gs <= gs;
            endcase
        end
    end

`ifdef STEP_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else if (step_upd && (gs != GS_WIN) && (step_cnt < 10'd999)) begin
            step_cnt <= step_cnt + 10'd1;
        end
    end
`endif

endmodule
